// File: rtl/hash_vector_assembler.sv
// hash_vector_assembler
//   Collects NUM_WORDS words of WORD_WIDTH bits into one flat hash vector under a
//   valid/ready handshake. It records which words were written and detects when the
//   vector is complete. It flags out-of-range or repeated addresses and holds the
//   result until the next start.
//   Optional feed-forward stage: define HASH_ASM_FEEDFWD_EN to add an ADD state that
//   sums each assembled word with the matching prev_vector word before DONE.
module hash_vector_assembler #(
    parameter int WORD_WIDTH  = 32,
    parameter int NUM_WORDS   = 8,
    parameter bit BIT_REVERSE = 1'b1,
    localparam int VW = NUM_WORDS * WORD_WIDTH,
    localparam int AW = ($clog2(NUM_WORDS + 1) > 1) ? $clog2(NUM_WORDS + 1) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  init_sel,
    input  logic [VW-1:0]         prev_vector,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AW-1:0]         in_addr,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic [NUM_WORDS-1:0]  word_mask,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [VW-1:0]         hash_vector
);

`ifdef HASH_ASM_FEEDFWD_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_ADD = 2'd2, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_DONE = 2'd3} state_t;
`endif

    state_t                 state_q;
    logic [VW-1:0]          hash_q;
    logic [NUM_WORDS-1:0]   mask_q;
    logic                   ready_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   error_q;

    logic                   accept;
    logic                   in_range;
    logic                   dup;
    logic                   complete;
    logic [NUM_WORDS-1:0]   onehot;
    logic [NUM_WORDS-1:0]   next_mask;
    logic [WORD_WIDTH-1:0]  wr_word;
    logic [VW-1:0]          written_vector;

    assign accept    = in_valid & ready_q;
    assign in_range  = (in_addr < AW'(NUM_WORDS));
    // Out-of-range addresses shift the single bit past the top, leaving onehot zero.
    assign onehot    = NUM_WORDS'(1) << in_addr;
    assign dup       = |(mask_q & onehot);
    assign next_mask = mask_q | onehot;
    assign complete  = in_last | (&next_mask);

    // Incoming word in storage bit order (optionally mirrored).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_word = in_data;
        if (BIT_REVERSE) begin
            for (int b = 0; b < WORD_WIDTH; b++) begin
                wr_word[b] = in_data[WORD_WIDTH-1-b];
            end
        end
    end

    // Current vector with the addressed word replaced; unchanged for bad addresses.
    always_comb begin
        written_vector = hash_q;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (onehot[k]) begin
                written_vector[k*WORD_WIDTH +: WORD_WIDTH] = wr_word;
            end
        end
    end

`ifdef HASH_ASM_FEEDFWD_EN
    logic [VW-1:0] sum_vector;

    // Word-wise feed-forward sum; carries never cross a word boundary.
    always_comb begin
        sum_vector = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            sum_vector[k*WORD_WIDTH +: WORD_WIDTH] = hash_q[k*WORD_WIDTH +: WORD_WIDTH]
                                                   + prev_vector[k*WORD_WIDTH +: WORD_WIDTH];
        end
    end
`endif

    // Control FSM with registered handshake/status outputs and the vector storage.
    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= S_IDLE;
            hash_q  <= '0;
            mask_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        hash_q  <= init_sel ? prev_vector : '0;
                        mask_q  <= '0;
                        error_q <= 1'b0;
                        done_q  <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        hash_q <= written_vector;
                        mask_q <= next_mask;
                        if (!in_range || dup) begin
                            error_q <= 1'b1;
                        end
                        if (complete) begin
                            ready_q <= 1'b0;
`ifdef HASH_ASM_FEEDFWD_EN
                            state_q <= S_ADD;
`else
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
`endif
                        end
                    end
                end
`ifdef HASH_ASM_FEEDFWD_EN
                S_ADD: begin
                    hash_q  <= sum_vector;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign word_mask   = mask_q;
    assign hash_vector = hash_q;

endmodule

// File: tb/tb_hash_vector_assembler.sv
// tb_hash_vector_assembler
//   Instance A: 32-bit words x 8, bit-reversed, driven from a vector table plus
//   hand-written corner sequences. Instance B: 64-bit words x 4, straight, driven
//   by random traffic against a word-array reference model.
//   Expectations follow HASH_ASM_FEEDFWD_EN when it is defined.
module tb_hash_vector_assembler;

`ifdef HASH_ASM_FEEDFWD_EN
    localparam bit FF = 1'b1;
`else
    localparam bit FF = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- instance A: 32 x 8, BIT_REVERSE=1 ----------------
    logic         a_start = 0, a_init = 0, a_valid = 0, a_last = 0;
    logic [255:0] a_prev = '0;
    logic [3:0]   a_addr = '0;
    logic [31:0]  a_data = '0;
    logic         a_ready, a_busy, a_done, a_err;
    logic [7:0]   a_mask;
    logic [255:0] a_hash;

    hash_vector_assembler #(.WORD_WIDTH(32), .NUM_WORDS(8), .BIT_REVERSE(1'b1)) dut_a (
        .clock(clock), .reset(reset), .start(a_start), .init_sel(a_init),
        .prev_vector(a_prev), .in_valid(a_valid), .in_ready(a_ready),
        .in_addr(a_addr), .in_data(a_data), .in_last(a_last),
        .word_mask(a_mask), .busy(a_busy), .done(a_done), .error(a_err),
        .hash_vector(a_hash)
    );

    // ---------------- instance B: 64 x 4, BIT_REVERSE=0 ----------------
    logic         b_start = 0, b_init = 0, b_valid = 0, b_last = 0;
    logic [255:0] b_prev = '0;
    logic [2:0]   b_addr = '0;
    logic [63:0]  b_data = '0;
    logic         b_ready, b_busy, b_done, b_err;
    logic [3:0]   b_mask;
    logic [255:0] b_hash;

    hash_vector_assembler #(.WORD_WIDTH(64), .NUM_WORDS(4), .BIT_REVERSE(1'b0)) dut_b (
        .clock(clock), .reset(reset), .start(b_start), .init_sel(b_init),
        .prev_vector(b_prev), .in_valid(b_valid), .in_ready(b_ready),
        .in_addr(b_addr), .in_data(b_data), .in_last(b_last),
        .word_mask(b_mask), .busy(b_busy), .done(b_done), .error(b_err),
        .hash_vector(b_hash)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- model for instance A ----------------
    logic [31:0] e[8];

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int b = 0; b < 32; b++) r[b] = x[31-b];
        return r;
    endfunction

    function automatic logic [255:0] pack_a();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = e[k];
        return v;
    endfunction

    task automatic a_start_vec(input logic init);
        a_init  = init;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int k = 0; k < 8; k++) e[k] = init ? a_prev[k*32 +: 32] : 32'h0;
    endtask

    task automatic a_write(input logic [3:0] addr, input logic [31:0] data, input logic last);
        a_valid = 1'b1;
        a_addr  = addr;
        a_data  = data;
        a_last  = last;
        tick();
        a_valid = 1'b0;
        a_last  = 1'b0;
        a_data  = $urandom;
        if (addr < 4'd8) e[addr[2:0]] = rev32(data);
    endtask

    // Waits out the feed-forward cycle (when built in) and checks completion timing.
    task automatic a_expect_completion(input string tag);
        if (FF) begin
            check({tag, "_add_done"}, a_done, 1'b0);
            check({tag, "_add_busy"}, a_busy, 1'b1);
            check({tag, "_add_ready"}, a_ready, 1'b0);
            tick();
            for (int k = 0; k < 8; k++) e[k] = e[k] + a_prev[k*32 +: 32];
        end
        check({tag, "_done"}, {a_done, a_busy, a_ready}, 3'b100);
    endtask

    typedef struct {
        bit          new_vec;
        bit          init;
        logic [3:0]  addr;
        logic [31:0] data;
        bit          last;
        logic [7:0]  exp_mask;
        bit          exp_err;
        bit          exp_done;
    } vec_t;

    vec_t tbl[$];

    // ---------------- model for instance B ----------------
    logic [63:0] mw[4];
    logic [3:0]  m_mask;
    bit          m_fill, m_add, m_done, m_err;

    function automatic logic [255:0] pack_b();
        logic [255:0] v;
        for (int k = 0; k < 4; k++) v[k*64 +: 64] = mw[k];
        return v;
    endfunction

    task automatic b_model_edge();
        if (reset) begin
            for (int k = 0; k < 4; k++) mw[k] = '0;
            m_mask = '0; m_fill = 0; m_add = 0; m_done = 0; m_err = 0;
        end else if (m_fill) begin
            if (b_valid) begin
                if (b_addr < 3'd4) begin
                    if (m_mask[b_addr[1:0]]) m_err = 1;
                    mw[b_addr[1:0]] = b_data;
                    m_mask[b_addr[1:0]] = 1'b1;
                end else begin
                    m_err = 1;
                end
                if (b_last || m_mask == 4'hF) begin
                    m_fill = 0;
                    if (FF) m_add = 1; else m_done = 1;
                end
            end
        end else if (m_add) begin
            for (int k = 0; k < 4; k++) mw[k] = mw[k] + b_prev[k*64 +: 64];
            m_add  = 0;
            m_done = 1;
        end else if (b_start) begin
            for (int k = 0; k < 4; k++) mw[k] = b_init ? b_prev[k*64 +: 64] : 64'h0;
            m_mask = '0; m_err = 0; m_done = 0; m_fill = 1;
        end
    endtask

    initial begin
        logic [255:0] snap;

        // ---- reset state ----
        tick(); tick();
        check("rst_a_status", {a_ready, a_busy, a_done, a_err, a_mask}, 12'h000);
        check("rst_a_hash", a_hash, '0);
        check("rst_b_status", {b_ready, b_busy, b_done, b_err, b_mask}, 8'h00);
        check("rst_b_hash", b_hash, '0);
        reset = 1'b0;
        tick();
        check("idle_a_ready", a_ready, 1'b0);

        // ---- table: full fill, seeded single write, duplicate/out-of-range ----
        a_prev = {8{32'hAAAA_AAAA}};
        for (int i = 0; i < 8; i++)
            tbl.push_back('{i == 0, 1'b0, 4'(i), 32'h0000_0001, 1'b0,
                            8'((16'h1 << (i + 1)) - 1), 1'b0, i == 7});
        tbl.push_back('{1'b1, 1'b1, 4'd3, 32'h1234_5678, 1'b1, 8'h08, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 4'd2, 32'h0000_0001, 1'b0, 8'h04, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'd2, 32'h0000_0002, 1'b0, 8'h04, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'd8, 32'hDEAD_BEEF, 1'b0, 8'h04, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'd0, 32'hC001_0000, 1'b1, 8'h05, 1'b1, 1'b1});

        foreach (tbl[i]) begin
            vec_t v;
            v = tbl[i];
            if (v.new_vec) begin
                a_start_vec(v.init);
                check("start_status", {a_ready, a_busy, a_done, a_err, a_mask}, 12'hC00);
                check("start_seed", a_hash, pack_a());
            end
            a_write(v.addr, v.data, v.last);
            check($sformatf("tbl%0d_mask", i), a_mask, v.exp_mask);
            check($sformatf("tbl%0d_err", i), a_err, v.exp_err);
            if (v.exp_done) a_expect_completion($sformatf("tbl%0d", i));
            else check($sformatf("tbl%0d_fill", i), {a_done, a_busy, a_ready}, 3'b011);
            check($sformatf("tbl%0d_hash", i), a_hash, pack_a());
        end

        // ---- DONE holds the result: offered words and changing prev are ignored ----
        snap = pack_a();
        a_valid = 1'b1; a_addr = 4'd1; a_data = 32'hFFFF_0000;
        a_prev = {8{32'h1357_9BDF}};
        tick(); tick(); tick();
        a_valid = 1'b0;
        check("done_hold_hash", a_hash, snap);
        check("done_hold_status", {a_ready, a_busy, a_done, a_err, a_mask}, 12'h305);

        // ---- start ignored mid-FILL, then reset discards the partial vector ----
        a_start_vec(1'b0);
        for (int i = 0; i < 4; i++) a_write(4'(i), 32'(i + 1), 1'b0);
        snap = pack_a();
        a_prev = {8{32'h5555_5555}};
        a_init = 1'b1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("fill_start_ignored_hash", a_hash, snap);
        check("fill_start_ignored_mask", {a_busy, a_ready, a_mask}, 10'h30F);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midfill_rst_hash", a_hash, '0);
        check("midfill_rst_status", {a_ready, a_busy, a_done, a_err, a_mask}, 12'h000);

        // ---- feed-forward word wrap on instance B (straight bit order) ----
        b_prev = {192'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        b_init = 1'b1; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_valid = 1'b1; b_addr = 3'd0; b_data = 64'h2; b_last = 1'b1;
        tick();
        b_valid = 1'b0; b_last = 1'b0;
        if (FF) begin
            check("ff_add_cycle", {b_done, b_busy, b_ready}, 3'b010);
            tick();
            check("ff_word0", b_hash, {192'h0, 64'h1});
        end else begin
            check("noff_word0", b_hash, {192'h0, 64'h2});
        end
        check("ff_done", {b_done, b_busy, b_ready, b_err, b_mask}, 8'h81);

        // ---- random traffic on instance B against the reference model ----
        reset = 1'b1;
        @(posedge clock);
        b_model_edge();
        #1;
        reset = 1'b0;
        for (int c = 0; c < 800; c++) begin
            reset   = ($urandom_range(0, 99) == 0);
            b_start = ($urandom_range(0, 5) == 0);
            b_init  = $urandom_range(0, 1);
            b_prev  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            b_valid = $urandom_range(0, 1);
            b_addr  = 3'($urandom_range(0, 5));
            b_data  = {$urandom, $urandom};
            b_last  = ($urandom_range(0, 7) == 0);
            @(posedge clock);
            b_model_edge();
            #1;
            check($sformatf("rand%0d_status", c), {b_ready, b_busy, b_done, b_err, b_mask},
                  {m_fill, m_fill | m_add, m_done, m_err, m_mask});
            check($sformatf("rand%0d_hash", c), b_hash, pack_b());
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
